sipo_word_rx: RTL and testbench

- Downstream consumer of the 4-bit right-shift serial-in/serial-out stage: collects its serial output stream into WIDTH-bit parallel words.
- Each word is presented on a registered output with a valid/ready handshake.
- Word alignment can be restarted at any time. Overflow is flagged when a completed word cannot be delivered.

---
 rtl/sipo_word_rx_if.sv | 70 +++++++
 rtl/sipo_word_rx.sv | 165 ++++++++++++++++
 tb/tb_sipo_word_rx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_word_rx_if.sv
// ---------------------------------------------------------------------------
// sipo_word_rx_if
//   Bundles the serial input side and the parallel output side of
//   sipo_word_rx into one interface.
//
//   Parameters:
//     WIDTH       data bits per assembled word
//
//   Signals:
//     sin         serial data bit
//     sin_valid   qualifies sin on the current edge
//     sync_clr    restart word alignment
//     pout_ready  consumer accepts pout this cycle
//     ovf_clr     clear sticky overflow flag
//     pout        assembled word
//     pout_valid  pout holds an undelivered word
//     busy        partial word in progress
//     ovf         sticky: a completed word was dropped
//     perr        parity error flag for the word on pout
//
//   Handshake: a word on pout is transferred on any rising clk edge where
//   pout_valid=1 and pout_ready=1. While pout_valid=1 and pout_ready=0 the
//   receiver holds pout, pout_valid and perr stable. pout_ready may be
//   driven independently of pout_valid; it has no effect while
//   pout_valid=0.
//
//   Modports:
//     master  producer/consumer side (drives serial input and pout_ready)
//     slave   the receiver itself
// ---------------------------------------------------------------------------
interface sipo_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_valid;
  logic             sync_clr;
  logic             pout_ready;
  logic             ovf_clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             busy;
  logic             ovf;
  logic             perr;

  modport master (
    output sin,
    output sin_valid,
    output sync_clr,
    output pout_ready,
    output ovf_clr,
    input  pout,
    input  pout_valid,
    input  busy,
    input  ovf,
    input  perr
  );

  modport slave (
    input  sin,
    input  sin_valid,
    input  sync_clr,
    input  pout_ready,
    input  ovf_clr,
    output pout,
    output pout_valid,
    output busy,
    output ovf,
    output perr
  );
endinterface

// File: rtl/sipo_word_rx.sv
// ---------------------------------------------------------------------------
// sipo_word_rx
//   Collects an LSB-first serial bit stream into WIDTH-bit words and presents
//   each completed word on a registered output with a valid/ready handshake.
//   Word alignment can be restarted with sync_clr. A word that completes
//   while the previous one is still waiting (pout_valid=1, pout_ready=0) is
//   dropped and sets the sticky ovf flag.
//
//   Optional feature (macro SIPO_WORD_RX_PARITY_CHK_EN):
//     After WIDTH data bits one further accepted bit is taken as an even
//     parity bit; perr reports XOR(data, parity) for the word on pout.
//     Without the macro words are exactly WIDTH bits and perr is 0.
//
//   Parameters:
//     WIDTH      data bits per word (minimum 2)
//
//   Ports:
//     clk        clock, all state changes on posedge
//     rst        asynchronous active-low reset
//     bus        sipo_word_rx_if.slave (serial input, parallel output,
//                status flags)
//     dbg_state  current alignment state (0 = COLLECT, 1 = PARITY)
// ---------------------------------------------------------------------------
module sipo_word_rx #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  sipo_word_rx_if.slave  bus,
  output logic [0:0]     dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pout_q;
  logic             valid_q;
  logic             busy_q;
  logic             ovf_q;

  logic             complete;
  logic             consume;
  logic             deliver;
  logic             drop;
  logic [WIDTH-1:0] word;

`ifdef SIPO_WORD_RX_PARITY_CHK_EN
  logic             perr_q;
  logic             word_perr;
`else
  // Without the parity stage the oldest shreg bit is shifted out on the
  // completing edge and never read.
  logic             unused_bit;
  assign unused_bit = shreg[0];
`endif

  // Completion detection and output-side decisions for this edge.
  always_comb begin
    consume  = valid_q & bus.pout_ready;
    complete = 1'b0;
    word     = {bus.sin, shreg[WIDTH-1:1]};
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
    word_perr = 1'b0;
    // The data bits are already in shreg; this edge carries the parity bit.
    if (bus.sin_valid && !bus.sync_clr && state == ST_PARITY) begin
      complete  = 1'b1;
      word      = shreg;
      word_perr = (^shreg) ^ bus.sin;
    end
`else
    if (bus.sin_valid && !bus.sync_clr && count == LAST_IDX) begin
      complete = 1'b1;
    end
`endif
    // A completed word loads if the slot is empty or is being emptied now.
    deliver = complete & (~valid_q | bus.pout_ready);
    drop    = complete & valid_q & ~bus.pout_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_COLLECT;
      count   <= '0;
      shreg   <= '0;
      busy_q  <= 1'b0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      // Input side: alignment counter and shift register.
      if (bus.sync_clr) begin
        state <= ST_COLLECT;
        if (bus.sin_valid) begin
          // The bit arriving with sync_clr is bit 0 of the new word.
          shreg  <= {bus.sin, {(WIDTH-1){1'b0}}};
          count  <= CNT_W'(1);
          busy_q <= 1'b1;
        end else begin
          shreg  <= '0;
          count  <= '0;
          busy_q <= 1'b0;
        end
      end else if (bus.sin_valid) begin
        if (complete) begin
          count  <= '0;
          busy_q <= 1'b0;
          state  <= ST_COLLECT;
        end else begin
          shreg  <= {bus.sin, shreg[WIDTH-1:1]};
          count  <= count + CNT_W'(1);
          busy_q <= 1'b1;
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
          if (count == LAST_IDX) begin
            state <= ST_PARITY;
          end
`endif
        end
      end

      // Output side: single-entry word register with handshake.
      if (deliver) begin
        pout_q  <= word;
        valid_q <= 1'b1;
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
        perr_q  <= word_perr;
`endif
      end else if (consume) begin
        valid_q <= 1'b0;
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
        perr_q  <= 1'b0;
`endif
      end

      // Sticky overflow; a new drop wins over a clear on the same edge.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.ovf        = ovf_q;
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
  assign bus.perr       = perr_q;
`else
  assign bus.perr       = 1'b0;
`endif
  assign dbg_state      = state;

endmodule

// File: tb/tb_sipo_word_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_word_rx
//   Directed bench for sipo_word_rx (WIDTH=8). Inputs are driven 1 time unit
//   after each rising edge; outputs are sampled at the same point, so each
//   sample reflects the edge just taken. Expected words are held in exp_q.
//   Works with and without SIPO_WORD_RX_PARITY_CHK_EN.
// ---------------------------------------------------------------------------
module tb_sipo_word_rx;

  localparam int WIDTH = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_word_rx_if #(.WIDTH(WIDTH)) bus ();
  logic [0:0] dbg_state;

  sipo_word_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag);
    logic [WIDTH-1:0] exp;
    exp = exp_q.pop_front();
    check(tag, 32'(bus.pout), 32'(exp));
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.sin       = b;
    bus.sin_valid = 1'b1;
    tick();
    bus.sin_valid = 1'b0;
  endtask

  // Sends one word LSB-first (plus parity bit when enabled); pout_ready and
  // ovf_clr take rdy_last / clr_last on the completing edge.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic par,
                           input logic rdy_last, input logic clr_last);
    for (int i = 0; i < WIDTH; i++) begin
`ifndef SIPO_WORD_RX_PARITY_CHK_EN
      if (i == WIDTH - 1) begin
        bus.pout_ready = rdy_last;
        bus.ovf_clr    = clr_last;
      end
`endif
      send_bit(w[i]);
    end
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
    bus.pout_ready = rdy_last;
    bus.ovf_clr    = clr_last;
    send_bit(par);
`endif
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int pulses;
    logic [WIDTH-1:0] seen;

    bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.sync_clr = 1'b0;
    bus.pout_ready = 1'b1; bus.ovf_clr = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    // Reset state, observed before any clock edge
    check("rst_pout",  32'(bus.pout), 0);
    check("rst_valid", 32'(bus.pout_valid), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_ovf",   32'(bus.ovf), 0);
    check("rst_perr",  32'(bus.perr), 0);
    tick();
    rst = 1'b1;
    tick();

    // Basic word 8'h4D, LSB first, busy tracking
    w = 8'h4D;
    exp_q.push_back(8'h4D);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i]);
      if (i < WIDTH - 1) check($sformatf("basic_busy%0d", i), 32'(bus.busy), 1);
    end
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
    check("basic_busy_par", 32'(bus.busy), 1);
    check("basic_state_par", 32'(dbg_state), 1);
    send_bit(^w);
`endif
    check("basic_valid", 32'(bus.pout_valid), 1);
    check_word("basic_pout");
    check("basic_busy_end", 32'(bus.busy), 0);
    check("basic_perr", 32'(bus.perr), 0);
    tick();
    check("basic_consumed", 32'(bus.pout_valid), 0);

    // Gaps of 1-3 idle cycles between bits
    pulses = 0;
    seen = '0;
    exp_q.push_back(8'h4D);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i]);
      if (bus.pout_valid) begin pulses++; seen = bus.pout; end
      for (int g = 0; g < 1 + (i % 3); g++) begin
        tick();
        if (bus.pout_valid) begin pulses++; seen = bus.pout; end
      end
    end
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
    send_bit(^w);
    if (bus.pout_valid) begin pulses++; seen = bus.pout; end
    tick();
    if (bus.pout_valid) begin pulses++; seen = bus.pout; end
`endif
    check("gap_pulses", 32'(pulses), 1);
    check("gap_pout", 32'(seen), 32'(exp_q.pop_front()));

    // Backpressure and overflow
    bus.pout_ready = 1'b0;
    send_word(8'hA5, ^8'hA5, 1'b0, 1'b0);
    check("bp_pout1", 32'(bus.pout), 32'h0A5);
    check("bp_valid1", 32'(bus.pout_valid), 1);
    check("bp_ovf1", 32'(bus.ovf), 0);
    send_word(8'h3C, ^8'h3C, 1'b0, 1'b0);
    check("bp_pout2", 32'(bus.pout), 32'h0A5);
    check("bp_valid2", 32'(bus.pout_valid), 1);
    check("bp_ovf2", 32'(bus.ovf), 1);
    bus.pout_ready = 1'b1;
    tick();
    check("bp_consumed", 32'(bus.pout_valid), 0);
    check("bp_ovf_sticky", 32'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("bp_ovf_clr", 32'(bus.ovf), 0);

    // Overflow and ovf_clr on the same edge: set wins
    bus.pout_ready = 1'b0;
    send_word(8'h0F, ^8'h0F, 1'b0, 1'b0);
    send_word(8'hF0, ^8'hF0, 1'b0, 1'b1);
    check("setwin_ovf", 32'(bus.ovf), 1);
    check("setwin_pout", 32'(bus.pout), 32'h00F);
    bus.pout_ready = 1'b1;
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("setwin_clr", 32'(bus.ovf), 0);
    check("setwin_consumed", 32'(bus.pout_valid), 0);

    // Complete + consume on the same edge
    bus.pout_ready = 1'b0;
    send_word(8'h11, ^8'h11, 1'b0, 1'b0);
    check("cc_pout1", 32'(bus.pout), 32'h011);
    send_word(8'h22, ^8'h22, 1'b1, 1'b0);
    check("cc_pout2", 32'(bus.pout), 32'h022);
    check("cc_valid", 32'(bus.pout_valid), 1);
    check("cc_ovf", 32'(bus.ovf), 0);
    tick();
    check("cc_consumed", 32'(bus.pout_valid), 0);

    // sync_clr with a bit on the same edge
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus.sync_clr = 1'b1;
    send_bit(1'b1);
    bus.sync_clr = 1'b0;
    check("sync_busy", 32'(bus.busy), 1);
    check("sync_state", 32'(dbg_state), 0);
    exp_q.push_back(8'hFF);
    for (int i = 1; i < WIDTH; i++) send_bit(1'b1);
`ifdef SIPO_WORD_RX_PARITY_CHK_EN
    send_bit(1'b0);
`endif
    check("sync_valid", 32'(bus.pout_valid), 1);
    check_word("sync_pout");
    tick();

    // sync_clr without a bit clears the partial word
    send_bit(1'b0); send_bit(1'b0);
    bus.sync_clr = 1'b1;
    tick();
    bus.sync_clr = 1'b0;
    check("sync_idle_busy", 32'(bus.busy), 0);
    exp_q.push_back(8'h4D);
    send_word(8'h4D, ^8'h4D, 1'b1, 1'b0);
    check_word("sync_idle_pout");
    tick();

`ifdef SIPO_WORD_RX_PARITY_CHK_EN
    // Parity checking
    send_word(8'h4D, 1'b0, 1'b1, 1'b0);
    check("par_ok_pout", 32'(bus.pout), 32'h04D);
    check("par_ok_perr", 32'(bus.perr), 0);
    tick();
    send_word(8'h4D, 1'b1, 1'b1, 1'b0);
    check("par_bad_pout", 32'(bus.pout), 32'h04D);
    check("par_bad_perr", 32'(bus.perr), 1);
    tick();
    check("par_consume_perr", 32'(bus.perr), 0);
    // A dropped word leaves perr of the held word alone
    bus.pout_ready = 1'b0;
    send_word(8'h4D, 1'b1, 1'b0, 1'b0);
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    check("par_drop_perr", 32'(bus.perr), 1);
    check("par_drop_ovf", 32'(bus.ovf), 1);
    bus.pout_ready = 1'b1;
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    // sync_clr during PARITY discards the partial word
    for (int i = 0; i < WIDTH; i++) send_bit(1'b1);
    bus.sync_clr = 1'b1;
    tick();
    bus.sync_clr = 1'b0;
    check("par_sync_state", 32'(dbg_state), 0);
    check("par_sync_valid", 32'(bus.pout_valid), 0);
`endif

    // Async reset mid-word with a pending word and ovf set
    bus.pout_ready = 1'b0;
    send_word(8'h5A, ^8'h5A, 1'b0, 1'b0);
    send_word(8'hC3, ^8'hC3, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus.pout_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_pout",  32'(bus.pout), 0);
    check("arst_valid", 32'(bus.pout_valid), 0);
    check("arst_busy",  32'(bus.busy), 0);
    check("arst_ovf",   32'(bus.ovf), 0);
    check("arst_perr",  32'(bus.perr), 0);
    #2 rst = 1'b1;
    tick();
    exp_q.push_back(8'h4D);
    send_word(8'h4D, ^8'h4D, 1'b1, 1'b0);
    check("arst_word_valid", 32'(bus.pout_valid), 1);
    check_word("arst_word_pout");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
